seq_multiplier: RTL and testbench

- Parametrised iterative shift-add multiplier with a start/ready/done handshake.
- Successor to the combinational array multiplier: one partial product per clock instead of an N_BITS-row adder array, for area-constrained datapaths.
- Adds optional two's-complement mode.
- Sits between a register-file/controller front end and any consumer that latches the product on done.

---
 rtl/seq_mult_pkg.sv | 16 +
 rtl/seq_multiplier_shift_add_step.sv | 26 ++
 rtl/seq_multiplier.sv | 119 +++++++++++
 tb/tb_seq_multiplier.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
// Build option: define SEQ_MULT_SIGNED_EN for two's-complement operands.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Product width for a given operand width.
    function automatic int prod_w(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/seq_multiplier_shift_add_step.sv
// One partial-product step: conditionally add the shifted multiplicand.
// Build option: none (shared by SEQ_MULT_SIGNED_EN and unsigned builds).
module shift_add_step
    import seq_mult_pkg::*;
#(
    parameter int N_BITS = 4,
    parameter int CNT_W  = $clog2(N_BITS + 1)
) (
    input  logic [prod_w(N_BITS)-1:0] acc,
    input  logic [N_BITS-1:0]         mcand,
    input  logic                      mbit,
    input  logic [CNT_W-1:0]          shamt,
    output logic [prod_w(N_BITS)-1:0] acc_next
);

    localparam int P = prod_w(N_BITS);

    logic [P-1:0] addend;

    // Add the multiplicand at weight 2^shamt when the multiplier bit is set.
    always_comb begin
        addend   = P'(mcand) << shamt;
        acc_next = mbit ? acc + addend : acc;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one partial product per clock.
// Build option: SEQ_MULT_SIGNED_EN adds signed_i (two's-complement mode).
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int N_BITS = 4,
    parameter int CNT_W  = $clog2(N_BITS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N_BITS-1:0]         x,
    input  logic [N_BITS-1:0]         y,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                      signed_i,
`endif
    output logic                      ready,
    output logic                      done,
    output logic [prod_w(N_BITS)-1:0] s
);

    localparam int P = prod_w(N_BITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BITS - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [N_BITS-1:0] xr, yr;
    logic [N_BITS-1:0] x_mag, y_mag;
    logic [P-1:0]      acc, acc_nxt, s_r, final_p;
    logic              accept, last;
    logic              neg_r, neg_in;

    assign s = s_r;

    // Operand magnitudes and result sign captured on an accepted start.
`ifdef SEQ_MULT_SIGNED_EN
    always_comb begin
        x_mag  = (signed_i && x[N_BITS-1]) ? -x : x;
        y_mag  = (signed_i && y[N_BITS-1]) ? -y : y;
        neg_in = signed_i && (x[N_BITS-1] ^ y[N_BITS-1]);
    end
`else
    always_comb begin
        x_mag  = x;
        y_mag  = y;
        neg_in = 1'b0;
    end
`endif

    shift_add_step #(
        .N_BITS (N_BITS),
        .CNT_W  (CNT_W)
    ) u_step (
        .acc      (acc),
        .mcand    (xr),
        .mbit     (yr[0]),
        .shamt    (cnt),
        .acc_next (acc_nxt)
    );

    // Final product, negated when exactly one signed operand was negative.
`ifdef SEQ_MULT_SIGNED_EN
    always_comb final_p = neg_r ? -acc_nxt : acc_nxt;
`else
    always_comb final_p = acc_nxt;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        last      = (cnt == LAST);
        unique case (state)
            IDLE: begin
                ready  = 1'b1;
                accept = start;
                if (start) state_nxt = BUSY;
            end
            BUSY: if (last) state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latch, accumulate/shift, product capture on DONE entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            xr    <= '0;
            yr    <= '0;
            acc   <= '0;
            s_r   <= '0;
            neg_r <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            xr    <= x_mag;
            yr    <= y_mag;
            acc   <= '0;
            neg_r <= neg_in;
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
            yr  <= yr >> 1;
            acc <= acc_nxt;
            if (last) s_r <= final_p;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (N_BITS=4).
// Build option: SEQ_MULT_SIGNED_EN also exercises the signed vectors.
module tb_seq_multiplier;

    localparam int N = 4;

    typedef struct {
        logic [7:0] p;
        int         c;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] x = '0;
    logic [3:0] y = '0;
    logic       signed_i = 1'b0;
    logic       ready, done;
    logic [7:0] s;

    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   done_prev = 1'b0;
    exp_t q[$];

    seq_multiplier #(.N_BITS(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .x        (x),
        .y        (y),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_i (signed_i),
`endif
        .ready    (ready),
        .done     (done),
        .s        (s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expected product and done cycle on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (done_prev) begin
            checks++;
            if (ready !== 1'b1) begin
                fails++;
                $display("FAIL ready_after_done: got %b want 1", ready);
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: cycle %0d s=%h", cyc, s);
            end else begin
                e = q.pop_front();
                if (s !== e.p) begin
                    fails++;
                    $display("FAIL product: got %h want %h", s, e.p);
                end
                checks++;
                if (cyc != e.c) begin
                    fails++;
                    $display("FAIL latency: done at %0d want %0d", cyc, e.c);
                end
                checks++;
                if (ready !== 1'b0) begin
                    fails++;
                    $display("FAIL ready_in_done: got %b want 0", ready);
                end
            end
        end
        done_prev = (done === 1'b1);
    end

    task automatic chk(input string name, input logic [7:0] got,
                       input logic [7:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Wait for ready, present one start, record the expected completion.
    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic sg, input logic [7:0] p,
                         input bit track);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {7'd0, ready}, 8'd1);
        start    = 1'b1;
        x        = a;
        y        = b;
        signed_i = sg;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.p = p;
        e.c = cyc + N;
        if (track) q.push_back(e);
    endtask

    // Bounded wait until the monitor has consumed every expected result.
    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d results missing", q.size());
            q.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_ready", {7'd0, ready}, 8'd1);
            chk("rst_done", {7'd0, done}, 8'd0);
            chk("rst_s", s, 8'h00);
        end

        issue(4'd15, 4'd15, 1'b0, 8'hE1, 1'b1);
        drain();

        issue(4'd0, 4'd9, 1'b0, 8'h00, 1'b1);
        issue(4'd6, 4'd0, 1'b0, 8'h00, 1'b1);
        issue(4'd7, 4'd3, 1'b0, 8'h15, 1'b1);
        drain();
        repeat (2) @(negedge clk);
        chk("s_hold_idle", s, 8'h15);

        issue(4'd5, 4'd3, 1'b0, 8'h0F, 1'b1);
        chk("s_hold_busy", s, 8'h15);
        @(negedge clk);
        start = 1'b1;
        x     = 4'd1;
        y     = 4'd1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (8) @(negedge clk);
        chk("s_after_ignored", s, 8'h0F);

        issue(4'd12, 4'd10, 1'b0, 8'h78, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_s", s, 8'h00);
        chk("abort_ready", {7'd0, ready}, 8'd1);
        chk("abort_done", {7'd0, done}, 8'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_s_idle", s, 8'h00);
        issue(4'd9, 4'd11, 1'b0, 8'h63, 1'b1);
        drain();

`ifdef SEQ_MULT_SIGNED_EN
        issue(4'h8, 4'h8, 1'b1, 8'h40, 1'b1);
        issue(4'h8, 4'h7, 1'b1, 8'hC8, 1'b1);
        issue(4'h3, 4'hF, 1'b1, 8'hFD, 1'b1);
        issue(4'hF, 4'hF, 1'b0, 8'hE1, 1'b1);
        drain();
`endif

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
